counter_checker: RTL

//  Receiving-end monitor for the free-running up/down counter outputs.
//  - Samples an up-count stream and a down-count stream each enabled cycle.
//  - Checks that each step is +1 (up) or -1 (down), modulo 2^WIDTH.
//  - Acquires lock after LOCK_CNT consecutive good steps.
//  - Counts and flags sequence errors once locked.
//  - Sits beside the counter in the same clock domain, on its output buses.

---
 rtl/counter_pkg.sv | 14 +
 rtl/counter_step_cmp.sv | 40 ++++
 rtl/counter_checker.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Package: counter_pkg
// Shared definitions for the counter_checker slice: FSM state encoding and
// the default stream width.
package counter_pkg;

   localparam int unsigned CC_DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      CC_IDLE = 2'd0,
      CC_ACQ  = 2'd1,
      CC_LOCK = 2'd2
   } cc_state_e;

endpackage

// File: rtl/counter_step_cmp.sv
// Module: counter_step_cmp
// Holds the previous sample of one counter stream and reports whether the
// current sample is exactly one step (DIR = +1 or -1) away, modulo 2^WIDTH.
// Ports:
//   clk      in   1      rising-edge clock
//   rst      in   1      synchronous active-high reset (prev value -> 0)
//   load     in   1      capture value as the new previous sample
//   value    in   WIDTH  current observed counter value
//   step_ok  out  1      value == prev + DIR (mod 2^WIDTH)
module counter_step_cmp
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH = CC_DEFAULT_WIDTH,
   parameter int          DIR   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] value,
   output logic             step_ok
);

   // DIR = -1 casts to all ones, so the add wraps into a decrement.
   localparam logic [WIDTH-1:0] STEP = WIDTH'(DIR);

   logic [WIDTH-1:0] prev_q;
   logic [WIDTH-1:0] expect_val;

   assign expect_val = prev_q + STEP;
   assign step_ok    = (value == expect_val);

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q <= '0;
      end else if (load) begin
         prev_q <= value;
      end
   end

endmodule

// File: rtl/counter_checker.sv
// Module: counter_checker
// Receiving-end monitor for an up/down counter pair. Checks each sampled step
// is +1 (up) / -1 (down) modulo 2^WIDTH, acquires lock after LOCK_CNT
// consecutive good steps and counts/flags sequence errors while locked.
// Optional build macro COUNTER_CHECKER_PAIR_CHECK_EN: when defined, a sample
// also requires dn_in == ~up_in; a pair violation marks both streams bad.
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   sample_en  in   1      up_in/dn_in valid this cycle
//   up_in      in   WIDTH  observed up-counter value
//   dn_in      in   WIDTH  observed down-counter value
//   clr_err    in   1      clears err_count and the sticky bad flags
//   locked     out  1      both streams tracked for >= LOCK_CNT steps
//   err_pulse  out  1      one-cycle flag for an error while locked
//   up_bad     out  1      last locked error involved the up stream
//   dn_bad     out  1      last locked error involved the down stream
//   err_count  out  ERR_W  saturating count of locked-state errors
module counter_checker
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH    = CC_DEFAULT_WIDTH,
   parameter int unsigned LOCK_CNT = 4,
   parameter int unsigned ERR_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sample_en,
   input  logic [WIDTH-1:0] up_in,
   input  logic [WIDTH-1:0] dn_in,
   input  logic             clr_err,
   output logic             locked,
   output logic             err_pulse,
   output logic             up_bad,
   output logic             dn_bad,
   output logic [ERR_W-1:0] err_count
);

   localparam logic [3:0] LOCK_RUN = 4'(LOCK_CNT);

   cc_state_e        state_q, state_d;
   logic [3:0]       run_q, run_d;
   logic             pulse_q, pulse_d;
   logic             up_bad_q, up_bad_d;
   logic             dn_bad_q, dn_bad_d;
   logic [ERR_W-1:0] cnt_q, cnt_d;

   logic up_ok, dn_ok;
   logic up_fail, dn_fail, good;

   counter_step_cmp #(
      .WIDTH (WIDTH),
      .DIR   (1)
   ) u_up_cmp (
      .clk     (clk),
      .rst     (rst),
      .load    (sample_en),
      .value   (up_in),
      .step_ok (up_ok)
   );

   counter_step_cmp #(
      .WIDTH (WIDTH),
      .DIR   (-1)
   ) u_dn_cmp (
      .clk     (clk),
      .rst     (rst),
      .load    (sample_en),
      .value   (dn_in),
      .step_ok (dn_ok)
   );

`ifdef COUNTER_CHECKER_PAIR_CHECK_EN
   logic pair_ok;
   assign pair_ok = (dn_in == ~up_in);
   assign up_fail = !up_ok || !pair_ok;
   assign dn_fail = !dn_ok || !pair_ok;
`else
   assign up_fail = !up_ok;
   assign dn_fail = !dn_ok;
`endif

   assign good = !up_fail && !dn_fail;

   always_comb begin
      state_d  = state_q;
      run_d    = run_q;
      pulse_d  = 1'b0;
      up_bad_d = up_bad_q;
      dn_bad_d = dn_bad_q;
      cnt_d    = cnt_q;

      // Clear first so a simultaneous locked error lands on a zeroed count.
      if (clr_err) begin
         cnt_d    = '0;
         up_bad_d = 1'b0;
         dn_bad_d = 1'b0;
      end

      if (sample_en) begin
         case (state_q)
            CC_IDLE: begin
               run_d   = '0;
               state_d = CC_ACQ;
            end
            CC_ACQ: begin
               if (good) begin
                  run_d = run_q + 4'd1;
                  if (run_q + 4'd1 == LOCK_RUN) begin
                     state_d = CC_LOCK;
                  end
               end else begin
                  run_d = '0;
               end
            end
            CC_LOCK: begin
               if (!good) begin
                  pulse_d  = 1'b1;
                  up_bad_d = up_fail;
                  dn_bad_d = dn_fail;
                  if (cnt_d != '1) begin
                     cnt_d = cnt_d + ERR_W'(1);
                  end
                  run_d   = '0;
                  state_d = CC_ACQ;
               end
            end
            default: begin
               run_d   = '0;
               state_d = CC_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= CC_IDLE;
         run_q    <= '0;
         pulse_q  <= 1'b0;
         up_bad_q <= 1'b0;
         dn_bad_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         run_q    <= run_d;
         pulse_q  <= pulse_d;
         up_bad_q <= up_bad_d;
         dn_bad_q <= dn_bad_d;
         cnt_q    <= cnt_d;
      end
   end

   assign locked    = (state_q == CC_LOCK);
   assign err_pulse = pulse_q;
   assign up_bad    = up_bad_q;
   assign dn_bad    = dn_bad_q;
   assign err_count = cnt_q;

endmodule
